// File: rtl/requant_stage_if.sv
// AXI-stream style handshake bundle shared by the requantizer and its neighbours.
interface axi_stream_if #(
  parameter int W = 32
) ();
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [W-1:0] tdata;

  modport axi_in  (input tvalid, input tdata, input tlast, output tready);
  modport axi_out (output tvalid, output tdata, output tlast, input tready);
endinterface

// File: rtl/requant_stage.sv
// Per-channel requantizer: multiply, round half toward +inf, shift and saturate.
// Three-stage elastic pipeline; each stage loads whenever it is empty or drains.
module requant_stage #(
  parameter int IN_W     = 32,
  parameter int D_W      = 32,
  parameter int MAX_BITS = 22,
  parameter int M_W      = 16,
  parameter int N_CH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_stream_if.axi_in              in_A,
  axi_stream_if.axi_out             out_Z,
  input  logic                      cfg_we,
  input  logic [$clog2(N_CH)-1:0]   cfg_addr,
  input  logic signed [M_W-1:0]     cfg_mult,
  input  logic [5:0]                cfg_shift
);

  localparam int AW = $clog2(N_CH);
  localparam int PW = IN_W + M_W;
  localparam int RW = PW + 1;

  // Saturation bounds, held one bit wider than the product so rounding never wraps.
  localparam logic signed [RW-1:0] SAT_HI = {{(RW-MAX_BITS+1){1'b0}}, {(MAX_BITS-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_LO = {{(RW-MAX_BITS+1){1'b1}}, {(MAX_BITS-1){1'b0}}};

  // Coefficient table
  logic signed [M_W-1:0] mult_tab  [N_CH];
  logic [5:0]            shift_tab [N_CH];
  logic                  cfg_hit;

  assign cfg_hit = 32'(cfg_addr) < N_CH;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        mult_tab[i]  <= {{(M_W-1){1'b0}}, 1'b1};
        shift_tab[i] <= 6'd0;
      end
    end else if (cfg_we && cfg_hit) begin
      mult_tab[cfg_addr]  <= cfg_mult;
      shift_tab[cfg_addr] <= cfg_shift;
    end
  end

  // Stage handshakes
  logic s0_valid;
  logic s1_valid;
  logic out_valid;
  logic rdy0;
  logic rdy1;
  logic rdy2;
  logic accept;

  assign rdy2        = out_Z.tready | ~out_valid;
  assign rdy1        = rdy2 | ~s1_valid;
  assign rdy0        = rdy1 | ~s0_valid;
  assign in_A.tready = rdy0;
  assign accept      = in_A.tvalid & rdy0;

  // Channel counter; tlast realigns the next beat to channel 0.
  logic [AW-1:0] ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch <= '0;
    end else if (accept) begin
      if (in_A.tlast || ch == AW'(N_CH - 1)) begin
        ch <= '0;
      end else begin
        ch <= ch + AW'(1);
      end
    end
  end

  // S0: capture beat and its coefficients (registered read sees the pre-write value)
  logic signed [IN_W-1:0] s0_data;
  logic                   s0_last;
  logic signed [M_W-1:0]  s0_mult;
  logic [5:0]             s0_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
    end else if (rdy0) begin
      s0_valid <= in_A.tvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s0_data  <= in_A.tdata;
      s0_last  <= in_A.tlast;
      s0_mult  <= mult_tab[ch];
      s0_shift <= shift_tab[ch];
    end
  end

  // S1: full-width signed product
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] s1_prod;
  logic                 s1_last;
  logic [5:0]           s1_shift;

  always_comb begin
    prod_c = PW'(s0_data) * PW'(s0_mult);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (rdy1) begin
      s1_valid <= s0_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy1 && s0_valid) begin
      s1_prod  <= prod_c;
      s1_last  <= s0_last;
      s1_shift <= s0_shift;
    end
  end

  // S2: round, shift, saturate
  logic signed [RW-1:0] ext_c;
  logic signed [RW-1:0] rnd_c;
  logic signed [RW-1:0] sum_c;
  logic signed [RW-1:0] shr_c;
  logic signed [RW-1:0] sat_c;
  logic [D_W-1:0]       res_c;

  always_comb begin
    ext_c = RW'(s1_prod);
    rnd_c = '0;
    if (s1_shift != 6'd0) begin
      rnd_c[s1_shift - 6'd1] = 1'b1;
    end
    sum_c = ext_c + rnd_c;
    shr_c = sum_c >>> s1_shift;
    if (shr_c > SAT_HI) begin
      sat_c = SAT_HI;
    end else if (shr_c < SAT_LO) begin
      sat_c = SAT_LO;
    end else begin
      sat_c = shr_c;
    end
    res_c = sat_c[D_W-1:0];
  end

  logic [D_W-1:0] out_data;
  logic           out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (rdy2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_c;
        out_last <= s1_last;
      end
    end
  end

  assign out_Z.tvalid = out_valid;
  assign out_Z.tdata  = out_data;
  assign out_Z.tlast  = out_last;

endmodule

// File: doc/requant_stage.md
REQUANT_STAGE -- requirements
Module: requant_stage

Interface
REQ-001 SHALL have parameter IN_W, default 32: signed accumulator input width.
REQ-002 SHALL have parameter D_W, default 32: output tdata width; result sign-extended to D_W.
REQ-003 SHALL have parameter MAX_BITS, default 22: saturation width, MAX_BITS <= D_W.
REQ-004 SHALL have parameter M_W, default 16: signed per-channel multiplier width.
REQ-005 SHALL have parameter N_CH, default 4: coefficient table depth, at least 2.
REQ-006 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port in_A  axi_stream_if.axi_in  IN_W  signed accumulators (tvalid/tready/tdata/tlast).
REQ-009 SHALL have port out_Z  axi_stream_if.axi_out  D_W  saturated requantized values; feeds residual adder.
REQ-010 SHALL have port cfg_we  in  1  coefficient write strobe.
REQ-011 SHALL have port cfg_addr  in  $clog2(N_CH)  coefficient table index.
REQ-012 SHALL have port cfg_mult  in  M_W  signed multiplier to write.
REQ-013 SHALL have port cfg_shift  in  6  right-shift amount to write, 0..47.

Function
REQ-014 SHALL keep table of N_CH {mult, shift} entries; cfg_we writes entry cfg_addr at clock edge; cfg_addr >= N_CH ignored.
REQ-015 SHALL keep channel counter ch, incremented per accepted input beat (tvalid & tready); wraps N_CH-1 -> 0; beat with tlast=1 forces next ch = 0.
REQ-016 SHALL use 3 register stages: S0 captures tdata, tlast and table[ch]; S1 computes signed product p = data*mult (IN_W+M_W bits); S2 rounds, shifts, saturates.
REQ-017 SHALL round half toward +inf: r = (p + 2^(shift-1)) >>> shift for shift > 0; r = p for shift = 0; rounding add performed without overflow.
REQ-018 SHALL saturate r to [-2^(MAX_BITS-1), 2^(MAX_BITS-1)-1], sign-extend to D_W.
REQ-019 SHALL give each stage ready = next_ready | ~stage_valid; out stage ready = out_Z.tready | ~out_Z.tvalid; in_A.tready = S0 ready.
REQ-020 SHALL have latency 3 cycles from input acceptance to out_Z.tvalid with no stall; sustained 1 beat/cycle.
REQ-021 SHALL hold out_Z.tdata/tlast stable while tvalid=1 and tready=0; no beat dropped or duplicated.
REQ-022 SHALL propagate tlast unchanged with its beat.
REQ-023 SHALL use pre-write table value when cfg write and S0 capture hit the same entry in the same cycle.
REQ-024 SHALL let bubbles collapse: an empty stage loads even when downstream stalled.

Reset
REQ-025 SHALL on rst clear all stage valids, out_Z.tvalid=0, out_Z.tlast=0, out_Z.tdata=0, ch=0.
REQ-026 SHALL on rst reset every table entry to mult=1, shift=0 (identity).
REQ-027 SHALL discard in-flight beats on rst mid-stream; first output after release is first beat accepted after release.

Verification
REQ-028 SHALL cover rounding: ch0 mult=3 shift=2; in 10 -> 8; in -10 -> -7; in 2 -> 2 (6+2=8>>2).
REQ-029 SHALL cover saturation: identity table; in 3000000 -> 2097151; in -3000000 -> -2097152; in 2097151 -> 2097151.
REQ-030 SHALL cover channel sequencing: mults 1,2,3,4 shift 0; six beats of 5, tlast on 6th -> 5,10,15,20,5,10; next beat of 5 -> 5.
REQ-031 SHALL cover backpressure: stream 1..8, tready low 5 cycles mid-stream -> in_A.tready drops after 3 held beats; out 1..8 in order, none lost.
REQ-032 SHALL cover latency: single beat 7 accepted cycle t, tready=1 -> out_Z.tvalid at t+3, tdata 7.
REQ-033 SHALL cover reset mid-stream: rst with 3 beats in flight -> out_Z.tvalid=0 next cycle, table identity, ch=0, no stale beat emitted.
